pwm_fade_ctrl: RTL

- Upstream duty-cycle sequencer for the multi-channel PWM generator.
- Produces a triangle-wave ("breathing") duty value per channel, with a fixed phase offset between channels.
- Advances only on PWM period boundaries, so duty never changes mid-period.
- Delivers each new duty vector over a valid/ready handshake; the PWM stage raises duty_ready when it latches a new set at its counter wrap.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_fade_lane.sv | 26 ++
 rtl/pwm_fade_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared definitions for the PWM fade sequencer.
//   fade_state_t : sequencer FSM states
//   PWM_MAX_DUTY / PWM_DUTY_W : default full-scale duty and duty width
//   tri_fold()   : folds a phase in 0..2*max-1 into a triangle 0..max..0
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    COMPUTE   = 2'd2,
    OFFER     = 2'd3
  } fade_state_t;

  localparam int PWM_MAX_DUTY = 100;
  localparam int PWM_DUTY_W   = 7;

  // Rising half maps straight through, falling half mirrors about max.
  function automatic int unsigned tri_fold(input int unsigned p, input int unsigned max);
    return (p <= max) ? p : (2 * max - p);
  endfunction

endpackage

// File: rtl/pwm_fade_lane.sv
// pwm_fade_lane -- combinational per-channel duty from the master phase.
//   phase : master phase, 0..2*MAX_DUTY-1
//   duty  : folded duty for channel CH_IDX, 0..MAX_DUTY
// Channel phase is master phase plus CH_IDX*CH_OFFSET; the parameter
// constraint keeps the sum below 4*MAX_DUTY, so one subtract wraps it.
module pwm_fade_lane import pwm_pkg::*; #(
  parameter int DUTY_W    = PWM_DUTY_W,
  parameter int MAX_DUTY  = PWM_MAX_DUTY,
  parameter int CH_OFFSET = 25,
  parameter int CH_IDX    = 0,
  parameter int PH_W      = $clog2(2 * PWM_MAX_DUTY) + 1
) (
  input  logic [PH_W-1:0]   phase,
  output logic [DUTY_W-1:0] duty
);

  localparam int OFS     = CH_IDX * CH_OFFSET;
  localparam int TWO_MAX = 2 * MAX_DUTY;

  logic [PH_W:0] p_raw, p_ch;

  assign p_raw = {1'b0, phase} + (PH_W+1)'(OFS);
  assign p_ch  = (p_raw >= (PH_W+1)'(TWO_MAX)) ? p_raw - (PH_W+1)'(TWO_MAX) : p_raw;
  assign duty  = DUTY_W'(tri_fold(32'(p_ch), MAX_DUTY));

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl -- triangle-wave ("breathing") duty sequencer for a
// multi-channel PWM stage. The master phase advances once every
// HOLD_PERIODS PWM periods; each new duty vector is offered on a
// valid/ready handshake and held stable until accepted.
//   clk, rst_n   : clock, async active-low reset
//   enable       : run/halt; low forces IDLE but keeps phase and outputs
//   period_done  : PWM counter-wrap pulse
//   duty_ready   : PWM stage accepts duty_vec
//   duty_valid   : duty_vec carries an unaccepted vector
//   duty_vec     : channel i at [i*DUTY_W +: DUTY_W]
//   ramp_dir     : 1 while channel 0 is on its rising half
//   cycle_cnt    : (only with PWM_FADE_CYCLE_CNT_EN) saturating count of
//                  master phase wraps, cleared while enable=0
module pwm_fade_ctrl import pwm_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int DUTY_W       = PWM_DUTY_W,
  parameter int MAX_DUTY     = PWM_MAX_DUTY,
  parameter int STEP         = 5,
  parameter int HOLD_PERIODS = 1,
  parameter int CH_OFFSET    = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     period_done,
  input  logic                     duty_ready,
  output logic                     duty_valid,
  output logic [NUM_CH*DUTY_W-1:0] duty_vec,
  output logic                     ramp_dir
`ifdef PWM_FADE_CYCLE_CNT_EN
  ,
  output logic [7:0]               cycle_cnt
`endif
);

  localparam int PH_W    = $clog2(2 * MAX_DUTY) + 1;
  localparam int HC_W    = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam int TWO_MAX = 2 * MAX_DUTY;

  fade_state_t state;
  logic [PH_W-1:0] phase;
  logic [HC_W-1:0] hold_cnt;

  // Phase advance with single conditional wrap (STEP <= MAX_DUTY).
  logic [PH_W:0]   phase_sum;
  logic            phase_wrap;
  logic [PH_W-1:0] phase_nxt;

  assign phase_sum  = {1'b0, phase} + (PH_W+1)'(STEP);
  assign phase_wrap = (phase_sum >= (PH_W+1)'(TWO_MAX));
  assign phase_nxt  = phase_wrap ? PH_W'(phase_sum - (PH_W+1)'(TWO_MAX))
                                 : phase_sum[PH_W-1:0];

  logic tick, advance;
  assign tick    = (state == WAIT_TICK) && period_done;
  assign advance = tick && (hold_cnt == HC_W'(HOLD_PERIODS - 1));

  // Lanes see the registered phase, which has already advanced by the
  // time the FSM sits in COMPUTE.
  logic [NUM_CH-1:0][DUTY_W-1:0] lane_duty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    pwm_fade_lane #(
      .DUTY_W    (DUTY_W),
      .MAX_DUTY  (MAX_DUTY),
      .CH_OFFSET (CH_OFFSET),
      .CH_IDX    (i),
      .PH_W      (PH_W)
    ) u_lane (
      .phase (phase),
      .duty  (lane_duty[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      hold_cnt   <= '0;
      duty_vec   <= '0;
      duty_valid <= 1'b0;
      ramp_dir   <= 1'b1;
    end else if (!enable) begin
      // Halt abandons any handshake; phase and outputs are retained so
      // fading resumes where it stopped.
      state      <= IDLE;
      hold_cnt   <= '0;
      duty_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= WAIT_TICK;
        WAIT_TICK: begin
          if (advance) begin
            hold_cnt <= '0;
            phase    <= phase_nxt;
            state    <= COMPUTE;
          end else if (tick) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        COMPUTE: begin
          duty_vec   <= lane_duty;
          ramp_dir   <= (phase < PH_W'(MAX_DUTY));
          duty_valid <= 1'b1;
          state      <= OFFER;
        end
        OFFER: begin
          if (duty_ready) begin
            duty_valid <= 1'b0;
            state      <= WAIT_TICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_FADE_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt <= '0;
    else if (!enable)
      cycle_cnt <= '0;
    else if (advance && phase_wrap && (cycle_cnt != 8'hFF))
      cycle_cnt <= cycle_cnt + 8'd1;
  end
`endif

endmodule
